// File: rtl/ps2_pkg.sv
// Shared scan-code constants, event record and receiver state encoding
// for the PS/2 keyboard event receiver.
package ps2_pkg;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_FE = 8'hFE;
    localparam logic [7:0] SC_00 = 8'h00;
    localparam logic [7:0] SC_FF = 8'hFF;

    typedef struct packed {
        logic [8:0] code;
        logic       make;
    } kbd_event_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Bytes that carry no key information and must not disturb prefix flags
    function automatic logic is_filler(input logic [7:0] b);
        return (b == SC_E1) || (b == SC_AA) || (b == SC_FA) ||
               (b == SC_FE) || (b == SC_00) || (b == SC_FF);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and filters the raw pins, shifts in
// 11-bit frames, checks start/parity/stop and aborts stalled frames.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILT_LEN       = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_raw,
    input  logic       ps2_dat_raw,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILT_LEN);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]     clk_sync;
    logic [1:0]     dat_sync;
    logic           clk_s;
    logic           dat_s;
    logic           kbd_clk;
    logic           kbd_clk_q;
    logic [FCW-1:0] filt_cnt;
    logic           fall;
    rx_state_t      state;
    rx_state_t      state_next;
    logic [7:0]     shift_q;
    logic [2:0]     bit_cnt;
    logic           parity_q;
    logic [TCW-1:0] to_cnt;
    logic           timeout;
    logic           parity_good;
    logic           byte_ok_c;
    logic           par_err_c;
    logic           frm_err_c;

    assign clk_s       = clk_sync[1];
    assign dat_s       = dat_sync[1];
    assign fall        = kbd_clk_q & ~kbd_clk;
    assign parity_good = ^{shift_q, parity_q};
    assign timeout     = (state != RX_IDLE) && !fall &&
                         (to_cnt == TCW'(TIMEOUT_CYCLES - 1));

    // Two-flop synchronisers; idle bus level is high
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_raw};
            dat_sync <= {dat_sync[0], ps2_dat_raw};
        end
    end

    // Glitch filter: kbd_clk follows only after FILT_LEN agreeing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_clk   <= 1'b1;
            kbd_clk_q <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            kbd_clk_q <= kbd_clk;
            if (clk_s == kbd_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILT_LEN - 1)) begin
                kbd_clk  <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (reset) state <= RX_IDLE;
        else       state <= state_next;
    end

    // Next-state logic, advanced by filtered falling edges or a timeout
    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = RX_IDLE;
        end else if (fall) begin
            case (state)
                RX_IDLE:   if (!dat_s) state_next = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) state_next = RX_PARITY;
                RX_PARITY: state_next = RX_STOP;
                RX_STOP:   state_next = RX_IDLE;
                default:   state_next = RX_IDLE;
            endcase
        end
    end

    // Frame outcome decode on the stop-bit edge (and start/timeout faults)
    always_comb begin
        byte_ok_c = 1'b0;
        par_err_c = 1'b0;
        frm_err_c = 1'b0;
        if (timeout) begin
            frm_err_c = 1'b1;
        end else if (fall) begin
            case (state)
                RX_IDLE: if (dat_s) frm_err_c = 1'b1;
                RX_STOP: begin
                    if (!dat_s)           frm_err_c = 1'b1;
                    else if (parity_good) byte_ok_c = 1'b1;
                    else                  par_err_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Shift register, bit counter and parity capture
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q  <= '0;
            bit_cnt  <= '0;
            parity_q <= 1'b0;
        end else if (fall) begin
            case (state)
                RX_IDLE: bit_cnt <= '0;
                RX_DATA: begin
                    shift_q <= {dat_s, shift_q[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                RX_PARITY: parity_q <= dat_s;
                default: ;
            endcase
        end
    end

    // Inactivity counter, cleared by every falling edge and while idle
    always_ff @(posedge clk) begin
        if (reset || fall || state == RX_IDLE) to_cnt <= '0;
        else                                  to_cnt <= to_cnt + 1'b1;
    end

    // Registered one-cycle result pulses and the received byte
    always_ff @(posedge clk) begin
        if (reset) begin
            data_byte  <= '0;
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= byte_ok_c;
            parity_err <= par_err_c;
            frame_err  <= frm_err_c;
            if (byte_ok_c) data_byte <= shift_q;
        end
    end

endmodule

// File: rtl/ps2_kbd_event_rx.sv
// PS/2 keyboard event receiver: decodes E0/F0 prefixes into 9-bit codes,
// tracks key state, optionally drops typematic repeats and queues
// make/break events in a first-word-fall-through FIFO.
module ps2_kbd_event_rx
    import ps2_pkg::*;
#(
    parameter int FILT_LEN        = 4,
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter int FIFO_DEPTH      = 8,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       ev_ready,
    input  logic [8:0] query_code,
    output logic       ev_valid,
    output logic [8:0] keyCode,
    output logic       make,
    output logic       brake,
    output logic       query_pressed,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic         ext_q;
    logic         brk_q;
    logic         dec_fire;
    kbd_event_t   dec_event;
    logic [511:0] key_state;
    logic         push_req;
    logic         push_ok;
    logic         pop;
    logic         full;
    kbd_event_t   fifo_mem [FIFO_DEPTH];
    kbd_event_t   head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    ps2_frame_rx #(
        .FILT_LEN      (FILT_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk        (clk),
        .reset      (resetN),
        .ps2_clk_raw(PS2_CLK),
        .ps2_dat_raw(PS2_DAT),
        .data_byte  (rx_byte),
        .byte_valid (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    // A key byte (not a prefix or filler) turns into an event using the prefix flags
    always_comb begin
        dec_fire  = 1'b0;
        dec_event = '0;
        if (rx_valid && rx_byte != SC_E0 && rx_byte != SC_F0 && !is_filler(rx_byte)) begin
            dec_fire       = 1'b1;
            dec_event.code = {ext_q, rx_byte};
            dec_event.make = ~brk_q;
        end
    end

    // Prefix flags: set by E0/F0, consumed by the next key byte
    always_ff @(posedge clk) begin
        if (resetN) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_E0) begin
                ext_q <= 1'b1;
            end else if (rx_byte == SC_F0) begin
                brk_q <= 1'b1;
            end else if (!is_filler(rx_byte)) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    // Per-key pressed table, updated even when the event itself is dropped
    always_ff @(posedge clk) begin
        if (resetN)        key_state <= '0;
        else if (dec_fire) key_state[dec_event.code] <= dec_event.make;
    end

    assign query_pressed = key_state[query_code];
    assign push_req = dec_fire &&
                      !(SUPPRESS_REPEAT && dec_event.make && key_state[dec_event.code]);
    assign ev_valid = (count != '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign pop      = ev_valid & ev_ready;
    assign push_ok  = push_req && (!full || pop);

    // Event storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= dec_event;
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (resetN) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push_req && !push_ok) overflow <= 1'b1;
        end
    end

    assign head    = fifo_mem[rd_ptr];
    assign keyCode = ev_valid ? head.code : 9'd0;
    assign make    = ev_valid & head.make;
    assign brake   = ev_valid & ~head.make;

endmodule

// File: tb/tb_ps2_kbd_event_rx.sv
// Self-checking bench for ps2_kbd_event_rx: drives PS/2 frames on the pins,
// keeps a spec-level event model and compares the FIFO head every cycle.
module tb_ps2_kbd_event_rx;

    localparam int FILT_LEN       = 4;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int FIFO_DEPTH     = 8;
    localparam int HALF           = 12;

    logic       clk = 1'b0;
    logic       resetN;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic       ev_ready;
    logic [8:0] query_code;
    logic       ev_valid, make, brake, query_pressed, parity_err, frame_err, overflow;
    logic [8:0] keyCode;
    logic       ev_valid2, make2, brake2, query_pressed2, parity_err2, frame_err2, overflow2;
    logic [8:0] keyCode2;

    int checks = 0;
    int errors = 0;
    int pops1 = 0;
    int pops2 = 0;
    int par_cnt = 0;
    int frm_cnt = 0;
    logic [8:0] last_pop = '0;

    // Spec-level model: expected events as {code, make}, key table, prefix flags
    logic [9:0]   model_q [$];
    bit   [511:0] model_table = '0;
    bit           m_ext = 1'b0;
    bit           m_brk = 1'b0;

    always #5 clk = ~clk;

    ps2_kbd_event_rx #(
        .FILT_LEN(FILT_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH), .SUPPRESS_REPEAT(1'b1)
    ) dut (
        .clk(clk), .resetN(resetN), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .ev_ready(ev_ready), .query_code(query_code), .ev_valid(ev_valid),
        .keyCode(keyCode), .make(make), .brake(brake), .query_pressed(query_pressed),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
    );

    ps2_kbd_event_rx #(
        .FILT_LEN(FILT_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH), .SUPPRESS_REPEAT(1'b0)
    ) dut_norep (
        .clk(clk), .resetN(resetN), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .ev_ready(1'b1), .query_code(query_code), .ev_valid(ev_valid2),
        .keyCode(keyCode2), .make(make2), .brake(brake2), .query_pressed(query_pressed2),
        .parity_err(parity_err2), .frame_err(frame_err2), .overflow(overflow2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Apply the decoder, table and FIFO rules to one good byte
    task automatic model_byte(input logic [7:0] b);
        logic [8:0] code;
        bit         mk;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE1 || b == 8'hAA || b == 8'hFA || b == 8'hFE ||
                 b == 8'h00 || b == 8'hFF) begin
        end else begin
            code  = {m_ext, b};
            mk    = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
            if (!(mk && model_table[code])) begin
                if (model_q.size() < FIFO_DEPTH) model_q.push_back({code, mk});
            end
            model_table[code] = mk;
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_table = '0;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    // One PS/2 bit cell: data set while clock high, then a low half-period
    task automatic ps2_bit(input logic d, input bit glitch);
        PS2_DAT = d;
        if (glitch) begin
            wait_cycles(3);
            PS2_CLK = 1'b0;
            wait_cycles(2);
            PS2_CLK = 1'b1;
            wait_cycles(HALF - 5);
        end else begin
            wait_cycles(HALF);
        end
        PS2_CLK = 1'b0;
        wait_cycles(HALF);
        PS2_CLK = 1'b1;
    endtask

    // Full frame; the model is updated as soon as the stop-bit edge is driven
    task automatic applyStimulus(input logic [7:0] b, input bit flip_par, input bit glitch);
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
        ps2_bit((~^b) ^ flip_par, glitch);
        PS2_DAT = 1'b1;
        wait_cycles(HALF);
        PS2_CLK = 1'b0;
        if (!flip_par) model_byte(b);
        wait_cycles(HALF);
        PS2_CLK = 1'b1;
        wait_cycles(2 * HALF);
    endtask

    task automatic query(input logic [8:0] code, input string name, input logic expected);
        query_code = code;
        #1;
        checkOutput(name, {31'd0, query_pressed}, {31'd0, expected});
    endtask

    // Per-cycle comparison of the FIFO head against the model, plus pulse counting
    always @(negedge clk) begin
        if (!resetN) begin
            if (parity_err) par_cnt++;
            if (frame_err) frm_cnt++;
            if (ev_valid2) pops2++;
            if (ev_valid2 && (brake2 === make2)) begin
                checks++;
                errors++;
                $display("[TB] FAIL norep_make_brake: make %0b brake %0b code %0h",
                         make2, brake2, keyCode2);
            end
            checks++;
            if (ev_valid) begin
                if (model_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL event_unexpected: got code %0h make %0b, expected none",
                             keyCode, make);
                end else begin
                    if ({keyCode, make, brake} !== {model_q[0], ~model_q[0][0]}) begin
                        errors++;
                        $display("[TB] FAIL event_head: got code %0h make %0b brake %0b, expected code %0h make %0b",
                                 keyCode, make, brake, model_q[0][9:1], model_q[0][0]);
                    end
                    if (ev_ready) begin
                        void'(model_q.pop_front());
                        pops1++;
                        last_pop = keyCode;
                    end
                end
            end else if ({keyCode, make, brake} !== 11'd0) begin
                errors++;
                $display("[TB] FAIL head_empty: got code %0h make %0b brake %0b, expected zeros",
                         keyCode, make, brake);
            end
        end
    end

    initial begin
        int p1;
        int p2;
        int pe;
        int fe;
        resetN     = 1'b1;
        PS2_CLK    = 1'b1;
        PS2_DAT    = 1'b1;
        ev_ready   = 1'b1;
        query_code = '0;
        wait_cycles(3);
        resetN = 1'b0;
        wait_cycles(1);
        checkOutput("reset_ev_valid", {31'd0, ev_valid}, 32'd0);
        checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("reset_keycode", {23'd0, keyCode}, 32'd0);
        checkOutput("reset_errs", {30'd0, parity_err, frame_err}, 32'd0);

        $display("[TB] make/break of 0x1C");
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkOutput("a_make_code", {23'd0, last_pop}, 32'h01C);
        query(9'h01C, "a_pressed", 1'b1);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        query(9'h01C, "a_released", 1'b0);
        checkOutput("a_pops", pops1, 32'd2);

        $display("[TB] extended 0x75");
        applyStimulus(8'hE0, 1'b0, 1'b0);
        applyStimulus(8'h75, 1'b0, 1'b0);
        checkOutput("ext_code", {23'd0, last_pop}, 32'h175);
        query(9'h175, "ext_pressed", 1'b1);
        query(9'h075, "plain_75_idle", 1'b0);
        applyStimulus(8'hE0, 1'b0, 1'b0);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h75, 1'b0, 1'b0);
        query(9'h175, "ext_released", 1'b0);
        query(9'h075, "plain_75_never", 1'b0);

        $display("[TB] parity error then good frame");
        pe = par_cnt;
        p1 = pops1;
        applyStimulus(8'h1C, 1'b1, 1'b0);
        checkOutput("parity_pulse", par_cnt - pe, 32'd1);
        checkOutput("parity_no_event", pops1 - p1, 32'd0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkOutput("after_parity_event", pops1 - p1, 32'd1);
        query(9'h01C, "after_parity_pressed", 1'b1);

        $display("[TB] typematic repeat");
        p1 = pops1;
        p2 = pops2;
        for (int i = 0; i < 3; i++) applyStimulus(8'h29, 1'b0, 1'b0);
        checkOutput("repeat_suppressed", pops1 - p1, 32'd1);
        checkOutput("repeat_passed", pops2 - p2, 32'd3);

        $display("[TB] FIFO full");
        @(posedge clk);
        #1 ev_ready = 1'b0;
        for (int i = 0; i < 9; i++) applyStimulus(8'h30 + 8'(i), 1'b0, 1'b0);
        checkOutput("full_valid", {31'd0, ev_valid}, 32'd1);
        checkOutput("full_overflow", {31'd0, overflow}, 32'd1);
        checkOutput("full_head", {23'd0, keyCode}, 32'h030);
        query(9'h038, "dropped_still_pressed", 1'b1);
        p1 = pops1;
        @(posedge clk);
        #1 ev_ready = 1'b1;
        wait_cycles(20);
        checkOutput("drain_count", pops1 - p1, 32'd8);
        checkOutput("drain_last", {23'd0, last_pop}, 32'h037);
        checkOutput("drain_empty", {31'd0, ev_valid}, 32'd0);
        checkOutput("overflow_sticky", {31'd0, overflow}, 32'd1);

        $display("[TB] timeout and glitch filtering");
        fe = frm_cnt;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i[0], 1'b0);
        PS2_DAT = 1'b1;
        wait_cycles(TIMEOUT_CYCLES + 40);
        checkOutput("timeout_frame_err", frm_cnt - fe, 32'd1);
        fe = frm_cnt;
        PS2_CLK = 1'b0;
        wait_cycles(2);
        PS2_CLK = 1'b1;
        wait_cycles(20);
        applyStimulus(8'hF0, 1'b0, 1'b1);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkOutput("glitch_no_frame_err", frm_cnt - fe, 32'd0);
        checkOutput("glitch_break_code", {23'd0, last_pop}, 32'h01C);
        query(9'h01C, "glitch_released", 1'b0);

        $display("[TB] reset mid-frame");
        fe = frm_cnt;
        pe = par_cnt;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
        PS2_DAT = 1'b1;
        @(posedge clk);
        #1 resetN = 1'b1;
        model_reset();
        wait_cycles(1);
        resetN = 1'b0;
        wait_cycles(TIMEOUT_CYCLES + 40);
        checkOutput("midreset_no_err", (frm_cnt - fe) + (par_cnt - pe), 32'd0);
        checkOutput("midreset_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("midreset_valid", {31'd0, ev_valid}, 32'd0);
        query(9'h030, "midreset_table", 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkOutput("post_reset_event", {23'd0, last_pop}, 32'h01C);
        checkOutput("model_drained", model_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
